// File: rtl/imem_writer.sv
// imem_writer: 32 x 32-bit instruction memory filled over a valid/ready load
// stream and read combinationally by the fetch path.
module imem_writer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic             load_done,
    output logic             load_err,
    output logic [5:0]       words_loaded,
    input  logic [63:0]      addr,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [5:0]       words_q, words_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic accept;
    logic session_start;
    logic final_word;

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        session_start = (state_q == ST_IDLE) && load_start;
        accept        = (state_q == ST_LOAD) && load_valid;
        final_word    = accept && (load_last || (ptr_q == LAST_IDX));
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a session ends on load_last or on the 32nd word.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so
        // no latch is inferred when a case arm leaves the signal alone.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_start) state_d = ST_LOAD;
            ST_LOAD: if (final_word) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decode straight from the state flop, so both are registered.
    always_comb begin
        load_ready = (state_q == ST_LOAD);
        load_done  = (state_q == ST_DONE);
    end

    // Datapath next values: pointer, counters, error flag and the array.
    always_comb begin
        ptr_d   = ptr_q;
        words_d = words_q;
        err_d   = err_q;
        mem_d   = mem_q;
        if (session_start) begin
            ptr_d   = '0;
            words_d = '0;
            err_d   = 1'b0;
        end
        if (accept) begin
            mem_d[ptr_q] = load_data;
            ptr_d        = ptr_q + PTR_W'(1);
            words_d      = words_q + 6'd1;
            // Hitting the last entry without load_last means the stream was cut.
            if ((ptr_q == LAST_IDX) && !load_last) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers, including the storage array.
    // NOTE: the array has a reset because the fetch side must read zeros
    // after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            ptr_q   <= ptr_d;
            words_q <= words_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    // Fetch read: out-of-range word indices return all ones.
    always_comb begin
        if (|addr[63:PTR_W]) begin
            data = '1;
        end else begin
            data = mem_q[addr[PTR_W-1:0]];
        end
    end

    assign words_loaded = words_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_imem_writer.sv
// Testbench for imem_writer: directed load sessions with a scoreboard that
// checks session results on load_done and fetch data on each read request.
module tb_imem_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic        load_err;
    logic [5:0]  words_loaded;
    logic [63:0] addr = '0;
    logic [31:0] data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [5:0] words;
        logic       err;
    } sess_t;

    sess_t       sess_q[$];
    logic [31:0] rd_q[$];
    logic [63:0] rd_addr_q[$];
    logic        rd_req = 1'b0;

    imem_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .addr         (addr),
        .data         (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Session monitor: every load_done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (load_done) begin
            if (sess_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected load_done: got 1 expected 0");
            end else begin
                sess_t s;
                s = sess_q.pop_front();
                check("session words_loaded", 64'(words_loaded), 64'(s.words));
                check("session load_err", 64'(load_err), 64'(s.err));
            end
        end
    end

    // Fetch monitor: compares data for each requested read.
    always @(negedge clk) begin
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch scoreboard empty: got request expected none");
            end else begin
                logic [31:0] e;
                logic [63:0] a;
                e = rd_q.pop_front();
                a = rd_addr_q.pop_front();
                check($sformatf("fetch data addr=%0h", a), 64'(data), 64'(e));
            end
        end
    end

    // All tasks below are entered and left one time unit after a rising edge.
    task automatic rd(input logic [63:0] a, input logic [31:0] exp);
        addr = a;
        rd_q.push_back(exp);
        rd_addr_q.push_back(a);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic start_session();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: got load_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("reset load_ready", 64'(load_ready), 64'd0);
        check("reset load_done", 64'(load_done), 64'd0);
        check("reset load_err", 64'(load_err), 64'd0);
        check("reset words_loaded", 64'(words_loaded), 64'd0);
        for (int i = 0; i < 32; i++) rd(64'(i), 32'h0);
        rd(64'd32, 32'hFFFF_FFFF);
        rd(64'h1_0000_0000, 32'hFFFF_FFFF);
        check("idle load_ready", 64'(load_ready), 64'd0);

        // Basic load
        start_session();
        check("ready after start", 64'(load_ready), 64'd1);
        sess_q.push_back(sess_t'{words: 6'd3, err: 1'b0});
        send(32'd15, 1'b0);
        send(32'd64, 1'b0);
        send(32'd89, 1'b1);
        check("basic done pulse", 64'(load_done), 64'd1);
        check("basic ready in done", 64'(load_ready), 64'd0);
        @(posedge clk);
        #1;
        check("basic done one cycle", 64'(load_done), 64'd0);
        rd(64'd0, 32'd15);
        rd(64'd1, 32'd64);
        rd(64'd2, 32'd89);
        rd(64'd3, 32'd0);

        // Reload and retention
        start_session();
        sess_q.push_back(sess_t'{words: 6'd1, err: 1'b0});
        send(32'h7, 1'b1);
        rd(64'd0, 32'h7);
        rd(64'd1, 32'd64);
        rd(64'd2, 32'd89);

        // Truncation at 32 words
        start_session();
        sess_q.push_back(sess_t'{words: 6'd32, err: 1'b1});
        for (int i = 0; i < 32; i++) send(32'(i + 100), 1'b0);
        check("trunc done pulse", 64'(load_done), 64'd1);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("trunc words held", 64'(words_loaded), 64'd32);
        check("trunc err held", 64'(load_err), 64'd1);
        rd(64'd0, 32'd100);
        rd(64'd1, 32'd101);
        rd(64'd31, 32'd131);

        // Error cleared by the next session start
        start_session();
        check("err cleared on start", 64'(load_err), 64'd0);
        check("words cleared on start", 64'(words_loaded), 64'd0);
        sess_q.push_back(sess_t'{words: 6'd1, err: 1'b0});
        send(32'h7, 1'b1);
        rd(64'd0, 32'h7);
        rd(64'd1, 32'd101);

        // Stalled producer: valid pattern 1,0,0,1
        start_session();
        sess_q.push_back(sess_t'{words: 6'd2, err: 1'b0});
        send(32'hA, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(32'hB, 1'b1);
        rd(64'd0, 32'hA);
        rd(64'd1, 32'hB);
        rd(64'd2, 32'd102);

        // Reset mid-session after 2 of 5 words
        start_session();
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst load_ready", 64'(load_ready), 64'd0);
        check("midrst load_done", 64'(load_done), 64'd0);
        check("midrst words_loaded", 64'(words_loaded), 64'd0);
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after reset ready", 64'(load_ready), 64'd0);
        for (int i = 0; i < 32; i++) rd(64'(i), 32'h0);
        rd(64'd32, 32'hFFFF_FFFF);

        @(posedge clk);
        #1;
        check("pending sessions", 64'(sess_q.size()), 64'd0);
        check("pending reads", 64'(rd_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
